// File: rtl/int2float_pkg.sv
`timescale 1ns/1ps
// Shared state encoding, default widths and constants for the int2float arbiter slice.
package int2float_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

  localparam int DEFAULT_INT_WIDTH = 32;
  localparam int DEFAULT_E_BIT     = 8;
  localparam int DEFAULT_F_BIT     = 23;

  localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

endpackage

// File: rtl/int2float.sv
`timescale 1ns/1ps
// Signed integer to float converter with one register stage; the fraction is truncated.
// A zero operand yields 1.0 (biased exponent, empty fraction), so callers correct zero themselves.
module int2float
  import int2float_pkg::*;
#(
  parameter int INT_WIDTH = DEFAULT_INT_WIDTH,
  parameter int E_bit     = DEFAULT_E_BIT,
  parameter int F_bit     = DEFAULT_F_BIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INT_WIDTH-1:0]   int_in,
  output logic [E_bit+F_bit:0]   float_out
);

  localparam int LW   = $clog2(INT_WIDTH);
  localparam int BIAS = (2 ** (E_bit - 1)) - 1;

  logic                 sgn;
  logic [INT_WIDTH-1:0] mag;
  logic [LW-1:0]        lead;
  logic [LW:0]          shamt;
  logic [INT_WIDTH-1:0] rem;
  logic [E_bit-1:0]     expo;
  logic [F_bit-1:0]     frac;

  always_comb begin
    sgn  = int_in[INT_WIDTH-1];
    mag  = sgn ? (~int_in + 1'b1) : int_in;
    lead = '0;
    for (int i = 0; i < INT_WIDTH; i++) begin
      if (mag[i]) lead = LW'(i);
    end
    // Shifting one past the leading one drops the hidden bit and left-aligns the rest.
    shamt = (LW + 1)'(INT_WIDTH) - {1'b0, lead};
    rem   = mag << shamt;
    frac  = F_bit'({rem, {F_bit{1'b0}}} >> INT_WIDTH);
    expo  = E_bit'(BIAS) + E_bit'(lead);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      float_out <= '0;
    end else begin
      float_out <= {sgn, expo, frac};
    end
  end

endmodule

// File: rtl/int2float_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one int2float converter among N_REQ valid/ready producers.
// Optional INT2FLOAT_ARB_STATS_EN adds a 16-bit completed-conversion counter (conv_count).
module int2float_arbiter
  import int2float_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int INT_WIDTH = DEFAULT_INT_WIDTH,
  parameter int E_bit     = DEFAULT_E_BIT,
  parameter int F_bit     = DEFAULT_F_BIT,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*INT_WIDTH-1:0]   req_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [E_bit+F_bit:0]         out_data,
  output logic [ID_W-1:0]              out_id
`ifdef INT2FLOAT_ARB_STATS_EN
  ,
  output logic [15:0]                  conv_count
`endif
);

  localparam int FW = E_bit + F_bit + 1;

  // Handshakes: a transfer happens in any cycle where valid and ready are both high.
  // Requesters hold data while valid; out_data/out_id are stable while out_valid && !out_ready.

  arb_state_t           state_q, state_d;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      id_reg;
  logic [INT_WIDTH-1:0] op_reg;
  logic                 zero_reg;
  logic                 grant_vld;
  logic [ID_W-1:0]      grant_idx;
  logic [INT_WIDTH-1:0] sel_data;
  logic                 accept;
  logic [FW-1:0]        float_out;

  // First valid requester at or after ptr, wrapping; returns {found, index}.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] v,
                                             input logic [ID_W-1:0]  ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [ID_W:0]      pos;
    logic               found;
    logic [ID_W-1:0]    idx;
    dbl   = {v, v} >> ptr;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        pos   = {1'b0, ptr} + (ID_W + 1)'(i);
        if (pos >= (ID_W + 1)'(N_REQ)) pos = pos - (ID_W + 1)'(N_REQ);
        idx   = ID_W'(pos);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_id    = '0;
    accept    = 1'b0;
    {grant_vld, grant_idx} = rr_pick(req_valid, rr_ptr);
    sel_data  = req_data[int'(grant_idx)*INT_WIDTH +: INT_WIDTH];
    case (state_q)
      IDLE: begin
        // No grant is offered while reset is held, so nothing is accepted then dropped.
        if (grant_vld && !rst) begin
          req_ready = N_REQ'(1) << grant_idx;
          accept    = 1'b1;
          state_d   = CONV;
        end
      end
      CONV: begin
        state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        out_data  = zero_reg ? FW'(FLOAT_ZERO) : float_out;
        out_id    = id_reg;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr   <= '0;
      op_reg   <= '0;
      id_reg   <= '0;
      zero_reg <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_reg   <= sel_data;
        id_reg   <= grant_idx;
        zero_reg <= (sel_data == '0);
        rr_ptr   <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  int2float #(
    .INT_WIDTH (INT_WIDTH),
    .E_bit     (E_bit),
    .F_bit     (F_bit)
  ) u_conv (
    .clk       (clk),
    .rst_n     (~rst),
    .int_in    (op_reg),
    .float_out (float_out)
  );

`ifdef INT2FLOAT_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_count <= '0;
    end else if (out_valid && out_ready) begin
      conv_count <= conv_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_int2float_arbiter.sv
`timescale 1ns/1ps
// Bench for int2float_arbiter: directed scenarios, then randomized traffic checked against a reference model.
module tb_int2float_arbiter;

  localparam int N_REQ     = 4;
  localparam int INT_WIDTH = 32;
  localparam int E_BIT     = 8;
  localparam int F_BIT     = 23;
  localparam int FW        = E_BIT + F_BIT + 1;
  localparam int ID_W      = 2;
  localparam int W         = ID_W + FW;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [N_REQ-1:0]           req_valid = '0;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ*INT_WIDTH-1:0] req_data = '0;
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic [FW-1:0]              out_data;
  logic [ID_W-1:0]            out_id;
`ifdef INT2FLOAT_ARB_STATS_EN
  logic [15:0]                conv_count;
`endif

  int checks    = 0;
  int failures  = 0;
  int cycle_cnt = 0;

  // Scoreboard: {id, float} expected in output order.
  logic [W-1:0] exp_q[$];
  int gnt_log[$];
  int gnt_cyc[$];

  int                model_ptr  = 0;
  bit                model_busy = 1'b0;
  int                hs_cycle   = -100;
  int                n_out      = 0;
  bit                prev_ov    = 1'b0;
  bit                prev_or    = 1'b0;
  logic [FW-1:0]     prev_od    = '0;
  logic [ID_W-1:0]   prev_oid   = '0;

  int2float_arbiter #(
    .N_REQ     (N_REQ),
    .INT_WIDTH (INT_WIDTH),
    .E_bit     (E_BIT),
    .F_bit     (F_BIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
`ifdef INT2FLOAT_ARB_STATS_EN
    ,
    .conv_count(conv_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt++;

  initial begin
`ifdef INT2FLOAT_ARB_STATS_EN
    #3_000_000;
`else
    #200_000;
`endif
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // IEEE-style value of a signed integer with the fraction truncated; zero maps to +0.0.
  function automatic logic [31:0] ref_float(input logic [31:0] v);
    longint m;
    longint frac;
    int     e;
    logic   sgn;
    if (v == 32'h0) return 32'h0;
    sgn = v[31];
    m   = sgn ? (64'sh1_0000_0000 - longint'({32'h0, v})) : longint'({32'h0, v});
    e   = 0;
    while ((m >> (e + 1)) != 0) e++;
    frac = ((m << 23) >> e) - (64'sd1 << 23);
    return {sgn, 8'(127 + e), frac[22:0]};
  endfunction

  function automatic int model_pick(input logic [N_REQ-1:0] v, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] mag;
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      default: begin
        mag = 32'($urandom_range(1, 32'h00FF_FFFF)) << $urandom_range(0, 7);
        return ($urandom_range(0, 1) != 0) ? (~mag + 32'd1) : mag;
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [N_REQ-1:0] mon_hs;
  int               mon_pick;
  int               mon_idx;
  logic [W-1:0]     mon_exp;
  bit               mon_exp_ov;

  always @(negedge clk) begin
    if (!rst) begin
      mon_hs = req_valid & req_ready;
      if (model_busy || req_valid == '0) begin
        check("req_ready_quiet", req_ready, 0);
      end else begin
        mon_pick = model_pick(req_valid, model_ptr);
        check("grant", req_ready, 1 << mon_pick);
      end
      mon_exp_ov = model_busy && (cycle_cnt >= hs_cycle + 2);
      check("out_valid", out_valid, mon_exp_ov);
      if (out_valid) begin
        if (prev_ov && !prev_or) begin
          check("hold_data", out_data, prev_od);
          check("hold_id", out_id, prev_oid);
        end
        if (out_ready) begin
          check("out_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check("out_data", out_data, mon_exp[FW-1:0]);
            check("out_id", out_id, mon_exp[W-1:FW]);
          end
          model_busy = 1'b0;
          n_out++;
        end
      end else begin
        check("out_data_idle", out_data, 0);
      end
      if (mon_hs != '0) begin
        mon_idx = 0;
        for (int i = N_REQ - 1; i >= 0; i--) if (mon_hs[i]) mon_idx = i;
        exp_q.push_back({ID_W'(mon_idx), ref_float(req_data[mon_idx*INT_WIDTH +: INT_WIDTH])});
        model_ptr  = (mon_idx + 1) % N_REQ;
        model_busy = 1'b1;
        hs_cycle   = cycle_cnt;
        gnt_log.push_back(mon_idx);
        gnt_cyc.push_back(cycle_cnt);
      end
      prev_ov  = out_valid;
      prev_or  = out_ready;
      prev_od  = out_data;
      prev_oid = out_id;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    rst        = 1'b1;
    model_ptr  = 0;
    model_busy = 1'b0;
    hs_cycle   = -100;
    n_out      = 0;
    prev_ov    = 1'b0;
    prev_or    = 1'b0;
    exp_q.delete();
  endtask

  task automatic send(input int id, input logic [31:0] d);
    int guard = 0;
    req_data[id*INT_WIDTH +: INT_WIDTH] = d;
    req_valid[id] = 1'b1;
    settle();
    while (!req_ready[id] && guard < 50) begin
      guard++;
      settle();
    end
    if (!req_ready[id]) check("send_accepted", req_ready[id], 1);
    align();
    req_valid[id] = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] d, input logic [ID_W-1:0] id);
    int guard = 0;
    settle();
    while (!out_valid && guard < 20) begin
      guard++;
      settle();
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_id"}, out_id, id);
    align();
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && guard < 30) begin
      guard++;
      settle();
    end
    check("drain_empty", exp_q.size(), 0);
    align();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [N_REQ-1:0] hs;
    int guard;
    int start;

    // Reset state, with every requester asserting valid during reset.
    assert_reset();
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
`ifdef INT2FLOAT_ARB_STATS_EN
    check("rst_conv_count", conv_count, 0);
`endif
    req_valid = '0;
    align();
    rst = 1'b0;
    align();

    // Basic conversions and zero correction.
    out_ready = 1'b1;
    send(0, 32'd5);
    expect_result("five", 32'h40A0_0000, 0);
    send(2, 32'hFFFF_FFFF);
    expect_result("minus_one", 32'hBF80_0000, 2);
    send(1, 32'h0000_0000);
    expect_result("zero", 32'h0000_0000, 1);

    // Backpressure: result held for 5 cycles with requester 0 waiting.
    out_ready = 1'b0;
    send(3, 32'd1000);
    guard = 0;
    settle();
    while (!out_valid && guard < 20) begin
      guard++;
      settle();
    end
    check("bp_first_data", out_data, 32'h447A_0000);
    req_data[0*INT_WIDTH +: INT_WIDTH] = 32'd77;
    req_valid[0] = 1'b1;
    for (int k = 1; k < 5; k++) begin
      settle();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 32'h447A_0000);
      check("bp_id", out_id, 3);
      check("bp_req_ready", req_ready, 0);
    end

    // Release on cycle 6 while all requesters assert valid: grants 0,1,2,3,0 three cycles apart.
    align();
    req_data[1*INT_WIDTH +: INT_WIDTH] = 32'hFFFF_FF00;
    req_data[2*INT_WIDTH +: INT_WIDTH] = 32'd0;
    req_data[3*INT_WIDTH +: INT_WIDTH] = 32'd123456;
    req_valid = '1;
    out_ready = 1'b1;
    start = gnt_log.size();
    guard = 0;
    while (gnt_log.size() < start + 5 && guard < 40) begin
      guard++;
      settle();
    end
    align();
    req_valid = '0;
    check("rr_count", gnt_log.size() >= start + 5, 1);
    if (gnt_log.size() >= start + 5) begin
      for (int k = 0; k < 5; k++) check("rr_order", gnt_log[start + k], k % N_REQ);
      for (int k = 1; k < 5; k++) check("rr_spacing", gnt_cyc[start + k] - gnt_cyc[start + k - 1], 3);
    end
    drain();

    // Reset during HOLD discards the result and returns the pointer to 0.
    out_ready = 1'b0;
    send(2, 32'd123);
    guard = 0;
    settle();
    while (!out_valid && guard < 20) begin
      guard++;
      settle();
    end
    check("pre_rst_hold", out_valid, 1);
    align();
    assert_reset();
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_id", out_id, 0);
    align();
    rst = 1'b0;
    req_data[1*INT_WIDTH +: INT_WIDTH] = 32'h8000_0000;
    req_data[3*INT_WIDTH +: INT_WIDTH] = 32'd42;
    req_valid = 4'b1010;
    settle();
    check("post_rst_grant", req_ready, 4'b0010);
    align();
    req_valid = '0;
    out_ready = 1'b1;
    expect_result("most_neg", 32'hCF00_0000, 1);
    send(3, 32'd42);
    expect_result("forty_two", 32'h4228_0000, 3);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_data[i*INT_WIDTH +: INT_WIDTH] = rand_operand();
          req_valid[i] = 1'b1;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      settle();
      hs = req_valid & req_ready;
      align();
      req_valid = req_valid & ~hs;
    end
    req_valid = '0;
    drain();
    check("random_outputs_seen", n_out > 50, 1);

`ifdef INT2FLOAT_ARB_STATS_EN
    check("conv_count_running", conv_count, 16'(n_out));
    // Counter wrap: 0x1_0002 completed conversions leave 2.
    assert_reset();
    align();
    rst = 1'b0;
    out_ready = 1'b1;
    req_data[0*INT_WIDTH +: INT_WIDTH] = 32'd9;
    req_valid = 4'b0001;
    guard = 0;
    while (n_out < 32'h1_0002 && guard < 250_000) begin
      guard++;
      settle();
    end
    align();
    req_valid = '0;
    drain();
    check("conv_count_wrap", conv_count, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int2float_arbiter.md
# int2float_arbiter

Shares one `int2float` converter among `N_REQ` integer producers. Each requester uses a valid/ready handshake. The block picks requesters round-robin, sequences the operand through the converter, and returns the float with the requester ID over a backpressured output port. Zero inputs are corrected to +0.0. It sits between the fixed-point front-end channels and the float pipeline.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..16.
- `INT_WIDTH`, 32: integer operand width. It is fixed by the converter.
- `E_bit`, 8: exponent width, passed to the converter.
- `F_bit`, 23: fraction width, passed to the converter.
- `ID_W`, `$clog2(N_REQ)`: requester ID width. It is derived; do not override.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, `N_REQ`: per-requester operand valid.
- `req_ready`, out, `N_REQ`: per-requester accept. At most one bit is high (one-hot).
- `req_data`, in, `N_REQ*INT_WIDTH`: flattened operands. Requester i occupies `[i*INT_WIDTH +: INT_WIDTH]`.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accept.
- `out_data`, out, `E_bit+F_bit+1`: float result. It is forced to 0 while `out_valid` is low.
- `out_id`, out, `ID_W`: index of the requester that produced the result.
- `conv_count`, out, 16: completed-conversion counter. It exists only with `INT2FLOAT_ARB_STATS_EN`.

## Operation
- FSM states:
  - IDLE: combinationally grant the first requester with `req_valid` set, searching from `rr_ptr` upward with wrap. The grant drives that requester's `req_ready`. On an accepted handshake:
    - latch the requester's data into `op_reg` and its index into `id_reg`;
    - set `zero_reg = (data == 0)`;
    - set `rr_ptr = grant+1 mod N_REQ`;
    - go to CONV.
    - If no requester is valid, stay in IDLE with `req_ready` = 0.
  - CONV: `op_reg` is stable at the converter input, and the converter registers its result this cycle. `req_ready` = 0. Go to HOLD unconditionally.
  - HOLD: `out_valid` = 1.
    - `out_data` = `zero_reg` ? 0 : converter `float_out`. `op_reg` is held, so `float_out` is stable.
    - `out_id` = `id_reg`.
    - On `out_valid & out_ready`, go to IDLE. Otherwise hold all outputs unchanged.
- No new operand is accepted in CONV or HOLD. At most one conversion is outstanding.
- Zero correction: the converter maps 0 to 1.0, so the controller must return 0x0000_0000 for a zero operand.
- Most-negative input (0x8000_0000) passes through unmodified. The result is the converter's output, 0xCF00_0000.
- `rr_ptr` advances only on a granted handshake, never on idle cycles.
- `req_valid` changing while not granted has no effect. Requesters must hold data while valid.
- The converter's active-low reset input is driven from `~rst`.

## Timing
- Reset values: state IDLE; `rr_ptr` 0; `op_reg` 0; `id_reg` 0; `zero_reg` 0; `req_ready` 0; `out_valid` 0; `out_data` 0; `out_id` 0; `conv_count` 0.
- `req_ready` is combinational from state, `req_valid` and `rr_ptr`.
- Latency: for a handshake in cycle T, `out_valid` rises in cycle T+2.
- Throughput: one result per 3 cycles when `out_ready` is held high.
- Backpressure: `out_data` and `out_id` stay stable while `out_valid && !out_ready`, for any number of cycles.
- Reset asserted mid-operation (CONV or HOLD): outputs return to reset values immediately, and the in-flight result is discarded.
- Simultaneous requests: the grant is strictly round-robin from `rr_ptr`, so no requester waits more than N_REQ grants.

## Configuration
- `INT2FLOAT_ARB_STATS_EN`:
  - Defined: the `conv_count` port and a 16-bit counter exist. The counter increments on each output handshake and wraps 0xFFFF→0. It is cleared by `rst`.
  - Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- `int2float_pkg` holds:
  - the state enum (IDLE, CONV, HOLD);
  - the default widths `INT_WIDTH`/`E_bit`/`F_bit`;
  - the constant `FLOAT_ZERO`.
- One sub-module: the existing `int2float` converter, instantiated once.
- The round-robin priority search is implemented as a function in the arbiter, not as a separate module.

## Test plan
- Requester 0 sends 5 → `out_valid` at T+2, `out_data`=0x40A0_0000, `out_id`=0.
- Requester 2 sends 0xFFFF_FFFF (−1) → 0xBF80_0000, `out_id`=2. Requester 1 sends 0 → 0x0000_0000, not 0x3F80_0000.
- All 4 `req_valid` held high with `out_ready`=1 → grant order 0,1,2,3,0; results spaced 3 cycles apart.
- Requester 3 sends 1000, `out_ready` held low 5 cycles → 0x447A_0000 held stable, `req_ready` stays 0; the handshake on cycle 6 returns the FSM to IDLE.
- `rst` pulsed during HOLD → `out_valid`=0 and `rr_ptr`=0 immediately; the next request from requester 1 is granted normally.
- Stats build: 0x1_0002 completed conversions → `conv_count`=2 (wrap check).
